// File: rtl/genius_pkg.sv
// Shared definitions for the Genius playback sequencer: speed codes, FSM
// state encoding and the length thresholds used by automatic speed selection.
package genius_pkg;

  typedef enum logic [1:0] {
    SPD_025 = 2'd0,
    SPD_05  = 2'd1,
    SPD_1   = 2'd2,
    SPD_2   = 2'd3
  } spd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned AUTO_TH_05 = 4;
  localparam int unsigned AUTO_TH_1  = 8;
  localparam int unsigned AUTO_TH_2  = 12;

  // Longer sequences play faster so the total playback time stays bounded.
  function automatic spd_t auto_spd(input int unsigned len);
    if (len < AUTO_TH_05)     return SPD_025;
    else if (len < AUTO_TH_1) return SPD_05;
    else if (len < AUTO_TH_2) return SPD_1;
    else                      return SPD_2;
  endfunction

endpackage

// File: rtl/fsm_playback_sched_edge_rise.sv
// Rising-edge detector for one divider rate. The input is already synchronous
// to the system clock; the history flop resets low so a level that is high
// right after reset is seen as a rising edge.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic level_q;

  // One-cycle history of the input level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/fsm_playback_sched.sv
// Step-playback sequencer: turns the selected divider rate into tick pulses
// and walks through len steps, each an LED-on phase then an LED-off phase.
// Build option PLAYBACK_AUTOSPD_EN: derive the playback speed from len_i
// instead of spd_i (ports unchanged).
module fsm_playback_sched
  import genius_pkg::*;
#(
  parameter int LEN_W     = 5,
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 1
) (
  input  logic             clk_i,
  input  logic             r_i,
  input  logic             c025_i,
  input  logic             c05_i,
  input  logic             c1_i,
  input  logic             c2_i,
  input  logic [1:0]       spd_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             start_i,
  output logic             tick_o,
  output logic [LEN_W-1:0] step_o,
  output logic             led_on_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CNT_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [3:0]       levels;
  logic [3:0]       edges;
  logic             sel;
  spd_t             spd_start;
  spd_t             spd_q;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [LEN_W-1:0] len_q;

  assign levels = {c2_i, c1_i, c05_i, c025_i};

  // Edges are detected per rate before the mux, so a speed change never
  // manufactures an edge out of differing levels.
  for (genvar g = 0; g < 4; g++) begin : g_edge
    edge_rise u_edge (
      .clk   (clk_i),
      .rst   (r_i),
      .level (levels[g]),
      .pulse (edges[g])
    );
  end

`ifdef PLAYBACK_AUTOSPD_EN
  logic unused_spd;
  assign unused_spd = ^spd_i;
  assign spd_start  = auto_spd(32'(len_i));
`else
  assign spd_start  = spd_t'(spd_i);
`endif

  // Pick the edge of the speed latched at start.
  always_comb begin
    sel = 1'b0;
    case (spd_q)
      SPD_025: sel = edges[0];
      SPD_05:  sel = edges[1];
      SPD_1:   sel = edges[2];
      SPD_2:   sel = edges[3];
      default: sel = 1'b0;
    endcase
  end

  // Playback FSM with registered outputs.
  always_ff @(posedge clk_i or posedge r_i) begin
    if (r_i) begin
      state    <= ST_IDLE;
      spd_q    <= SPD_025;
      len_q    <= '0;
      cnt      <= '0;
      tick_o   <= 1'b0;
      step_o   <= '0;
      led_on_o <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      tick_o <= sel & ((state == ST_ON) || (state == ST_OFF));
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            spd_q  <= spd_start;
            len_q  <= len_i;
            cnt    <= '0;
            step_o <= '0;
            busy_o <= 1'b1;
            if (len_i == '0) begin
              state <= ST_DONE;
            end else begin
              state    <= ST_ON;
              led_on_o <= 1'b1;
            end
          end
        end
        ST_ON: begin
          if (sel) begin
            if (cnt == CW'(ON_TICKS - 1)) begin
              cnt      <= '0;
              led_on_o <= 1'b0;
              state    <= ST_OFF;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ST_OFF: begin
          if (sel) begin
            if (cnt == CW'(OFF_TICKS - 1)) begin
              cnt <= '0;
              if (step_o == len_q - LEN_W'(1)) begin
                state <= ST_DONE;
              end else begin
                step_o   <= step_o + LEN_W'(1);
                led_on_o <= 1'b1;
                state    <= ST_ON;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ST_DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_playback_sched.sv
// Directed bench for fsm_playback_sched with scaled-down rate waveforms.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fsm_playback_sched;

  localparam int LEN_W = 5;

`ifdef PLAYBACK_AUTOSPD_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       cv = 4'b0000;
  logic [1:0]       spd = 2'd0;
  logic [LEN_W-1:0] len = '0;
  logic             start = 1'b0;
  logic             tick;
  logic [LEN_W-1:0] step;
  logic             led;
  logic             busy;
  logic             done;
  logic             t;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fsm_playback_sched #(.LEN_W(LEN_W), .ON_TICKS(2), .OFF_TICKS(1)) dut (
    .clk_i    (clk),
    .r_i      (rst),
    .c025_i   (cv[0]),
    .c05_i    (cv[1]),
    .c1_i     (cv[2]),
    .c2_i     (cv[3]),
    .spd_i    (spd),
    .len_i    (len),
    .start_i  (start),
    .tick_o   (tick),
    .step_o   (step),
    .led_on_o (led),
    .busy_o   (busy),
    .done_o   (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One short period of rate idx; reports tick_o as seen one cycle after the rise.
  task automatic rise(input int idx, output logic seen);
    cv[idx] = 1'b1;
    @(negedge clk);
    seen = tick;
    cv[idx] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_start(input logic [1:0] s, input logic [LEN_W-1:0] n);
    spd   = s;
    len   = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Two ON ticks then one OFF tick for step stp.
  task automatic play_step(input int idx, input int stp, input logic last);
    logic s;
    rise(idx, s);
    chk("tick_on1", 32'(s), 1);
    chk("led_after_1", 32'(led), 1);
    chk("step_on", 32'(step), 32'(stp));
    rise(idx, s);
    chk("tick_on2", 32'(s), 1);
    chk("led_after_2", 32'(led), 0);
    chk("step_off", 32'(step), 32'(stp));
    rise(idx, s);
    chk("tick_off", 32'(s), 1);
    if (!last) begin
      chk("step_next", 32'(step), 32'(stp + 1));
      chk("led_next", 32'(led), 1);
      chk("done_mid", 32'(done), 0);
    end else begin
      chk("done_last", 32'(done), 1);
      chk("busy_last", 32'(busy), 0);
      chk("step_last", 32'(step), 32'(stp));
    end
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_tick", 32'(tick), 0);
    chk("rst_step", 32'(step), 0);
    chk("rst_led", 32'(led), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1) spd=3 len=3: three ON/OFF pairs at the 2 Hz rate
    do_start(2'd3, 5'd3);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_led", 32'(led), 1);
    chk("t1_step", 32'(step), 0);
    chk("t1_tick", 32'(tick), 0);
    for (int s = 0; s < 3; s++) play_step(3, s, s == 2);
    @(negedge clk);
    chk("t1_done_once", 32'(done), 0);
    chk("t1_busy_end", 32'(busy), 0);

    // 2) len=0: immediate done, no LED, no tick even with a rate edge
    spd = 2'd3; len = '0; start = 1'b1; cv[3] = 1'b1;
    @(negedge clk);
    start = 1'b0; cv[3] = 1'b0;
    chk("t2_tick", 32'(tick), 0);
    chk("t2_led", 32'(led), 0);
    chk("t2_busy", 32'(busy), 1);
    chk("t2_done_early", 32'(done), 0);
    @(negedge clk);
    chk("t2_done", 32'(done), 1);
    chk("t2_busy_done", 32'(busy), 0);
    chk("t2_tick2", 32'(tick), 0);
    chk("t2_led2", 32'(led), 0);
    @(negedge clk);
    chk("t2_done_once", 32'(done), 0);

    // 3) restart while busy is ignored
    do_start(2'd3, 5'd2);
    rise(0, t);
    chk("t3_slow_ignored", 32'(t), 0);
    do_start(2'd0, 5'd9);
    play_step(3, 0, 1'b0);
    rise(0, t);
    chk("t3_rate_kept", 32'(t), 0);
    chk("t3_led_kept", 32'(led), 1);
    play_step(3, 1, 1'b1);
    @(negedge clk);

    // 4) async reset during ON of step 1
    do_start(2'd3, 5'd3);
    play_step(3, 0, 1'b0);
    rise(3, t);
    chk("t4_pre_led", 32'(led), 1);
    chk("t4_pre_step", 32'(step), 1);
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_step", 32'(step), 0);
    chk("t4_rst_led", 32'(led), 0);
    chk("t4_rst_busy", 32'(busy), 0);
    chk("t4_rst_tick", 32'(tick), 0);
    chk("t4_rst_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t4_idle_busy", 32'(busy), 0);
    do_start(2'd3, 5'd1);
    chk("t4_restart_busy", 32'(busy), 1);
    chk("t4_restart_led", 32'(led), 1);
    play_step(3, 0, 1'b1);
    @(negedge clk);

    // 5) spd=1 ignores c2, then follows c05
    do_start(2'd1, 5'd1);
    rise(3, t);
    chk("t5_wrong_rate1", 32'(t), 0);
    chk("t5_led1", 32'(led), 1);
    rise(3, t);
    chk("t5_wrong_rate2", 32'(t), 0);
    chk("t5_led2", 32'(led), 1);
    chk("t5_busy", 32'(busy), 1);
    play_step(1, 0, 1'b1);
    @(negedge clk);

    // 6) len=10 spd=0: auto build follows c1, default build follows c025
    do_start(2'd0, 5'd10);
    rise(0, t);
    chk("t6_c025", 32'(t), 32'(!AUTO));
    rise(2, t);
    chk("t6_c1", 32'(t), 32'(AUTO));
    chk("t6_led", 32'(led), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
